// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the shared issue stage.
// Bit i of each 2-bit vector, and slice i of each packed operand bus, belong to requester i.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [2*OPW-1:0]   req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_q;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of the execute-stage ALU between the integer pipe (0) and the
// address/branch helper (1); one issue register, result routed back to its owner.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OPW    = 4,
  parameter int MAX_OP = 9
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_q,
  output logic             busy
);
  localparam logic [OPW-1:0] MAX_OP_V = OPW'(MAX_OP);

  logic             occ;
  logic             owner;
  logic             err;
  logic             last_grant;
  logic             drain;
  logic             free;
  logic             accept;
  logic             grant;
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic [OPW-1:0]   op_g;

  always_comb begin
    drain = occ & bus.rsp_ready[owner];
    free  = ~occ | drain;
    grant = 1'b0;
    case (bus.req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    // Reset gating keeps req_ready low while rst is held, even if a requester is valid.
    accept = free & (|bus.req_valid) & ~rst;
    a_g    = grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    b_g    = grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    op_g   = grant ? bus.req_op[2*OPW-1:OPW]    : bus.req_op[OPW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 1'b0;
      owner      <= 1'b0;
      err        <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else if (accept) begin
      occ        <= 1'b1;
      owner      <= grant;
      last_grant <= grant;
      err        <= (op_g > MAX_OP_V);
      alu_a      <= a_g;
      alu_b      <= b_g;
      alu_op     <= op_g;
    end else if (drain) begin
      // Issue registers deliberately keep their values so the ALU inputs stay quiet.
      occ <= 1'b0;
    end
  end

  assign bus.req_ready = {accept & grant, accept & ~grant};
  assign bus.rsp_valid = {occ & owner, occ & ~owner};
  assign bus.rsp_q     = (occ & ~err) ? alu_q : '0;
  assign bus.rsp_err   = occ & err;
  assign busy          = occ;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepts push expected results, responses pop and compare,
// plus directed constant checks for latency, ordering, backpressure and reset.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int O = 4;

  typedef struct {
    logic         id;
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a, alu_b, alu_q;
  logic [O-1:0] alu_op;
  logic         busy;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_rsp = 0;
  exp_t sb[$];
  bit   grant_log[$];
  exp_t mon_e;

  alu_arbiter_if #(.WIDTH(W), .OPW(O)) bus ();

  alu_arbiter #(.WIDTH(W), .OPW(O), .MAX_OP(9)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_q  (alu_q),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [O-1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return {31'b0, a < b};
      4'd9:    return {31'b0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stand-in for the external ALU.
  always_comb alu_q = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [O-1:0] op);
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
    bus.req_op[i*O +: O] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    cycle();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          n_rsp++;
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("rsp_id", i, mon_e.id);
            check("rsp_q", bus.rsp_q, mon_e.q);
            check("rsp_err", bus.rsp_err, mon_e.err);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i]) begin
          logic [O-1:0] op;
          op = bus.req_op[i*O +: O];
          check("ready_needs_valid", bus.req_valid[i], 1);
          mon_e.id  = i[0];
          mon_e.err = (op > 4'd9);
          mon_e.q   = mon_e.err ? '0 : alu_fn(op, bus.req_a[i*W +: W], bus.req_b[i*W +: W]);
          sb.push_back(mon_e);
          grant_log.push_back(i[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [1:0] rdy;
    int         cnt0, cnt1, base;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b11;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_q", bus.rsp_q, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    cycle();
    rst = 1'b0;

    // Single requester, ADD 5+7.
    set_req(0, 5, 7, 4'd0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t1_ready", bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check("t1_rsp_q", bus.rsp_q, 12);
    check("t1_rsp_err", bus.rsp_err, 0);
    cycle();

    // Contention after reset: SUB 10-3 on req 0, XOR F0^FF on req 1.
    do_reset();
    grant_log.delete();
    set_req(0, 10, 3, 4'd1);
    set_req(1, 32'hF0, 32'hFF, 4'd4);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t2_ready0", bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("t2_rsp_valid0", bus.rsp_valid, 2'b01);
    check("t2_rsp_q0", bus.rsp_q, 7);
    check("t2_ready1", bus.req_ready, 2'b10);
    cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t2_rsp_valid1", bus.rsp_valid, 2'b10);
    check("t2_rsp_q1", bus.rsp_q, 32'h0F);
    cycle();
    check("t2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t2_grant0", grant_log[0], 0);
      check("t2_grant1", grant_log[1], 1);
    end

    // Backpressure: req 1 SLL 1<<4 held for 3 cycles while req 0 waits.
    set_req(1, 1, 4, 4'd5);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("t3_ready1", bus.req_ready, 2'b10);
    cycle();
    set_req(0, 2, 3, 4'd0);
    bus.req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", bus.rsp_valid, 2'b10);
      check("t3_hold_q", bus.rsp_q, 16);
      check("t3_hold_alu_a", alu_a, 1);
      check("t3_hold_alu_b", alu_b, 4);
      check("t3_hold_alu_op", alu_op, 5);
      check("t3_hold_ready", bus.req_ready, 2'b00);
      cycle();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("t3_release_ready", bus.req_ready, 2'b01);
    check("t3_release_valid", bus.rsp_valid, 2'b10);
    cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t3_next_valid", bus.rsp_valid, 2'b01);
    check("t3_next_q", bus.rsp_q, 5);
    cycle();

    // Illegal opcode C, then a legal OR.
    set_req(0, 1, 2, 4'hC);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t4_ready", bus.req_ready, 2'b01);
    cycle();
    set_req(0, 32'h3, 32'hC, 4'd3);
    @(negedge clk);
    check("t4_ill_valid", bus.rsp_valid, 2'b01);
    check("t4_ill_err", bus.rsp_err, 1);
    check("t4_ill_q", bus.rsp_q, 0);
    check("t4_ready2", bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t4_ok_valid", bus.rsp_valid, 2'b01);
    check("t4_ok_err", bus.rsp_err, 0);
    check("t4_ok_q", bus.rsp_q, 32'hF);
    cycle();

    // Streaming fairness: 4 ops from each requester, both always valid.
    do_reset();
    grant_log.delete();
    cnt0 = 0;
    cnt1 = 0;
    set_req(0, 0, 100, 4'd0);
    set_req(1, 1000, 0, 4'd1);
    bus.req_valid = 2'b11;
    base = n_rsp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      cycle();
      if (rdy[0]) begin
        cnt0++;
        if (cnt0 == 4) bus.req_valid[0] = 1'b0;
        else set_req(0, cnt0 * 3, 100, 4'd0);
      end
      if (rdy[1]) begin
        cnt1++;
        if (cnt1 == 4) bus.req_valid[1] = 1'b0;
        else set_req(1, 1000, cnt1, 4'd1);
      end
    end
    check("t5_rsp_count", n_rsp - base, 8);
    check("t5_grants", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("t5_grant_seq", grant_log[k], k % 2);

    // Reset while an op is held by backpressure.
    set_req(1, 7, 8, 4'd0);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("t6_ready1", bus.req_ready, 2'b10);
    cycle();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t6_busy_pre", busy, 1);
    check("t6_valid_pre", bus.rsp_valid, 2'b10);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("t6_async_valid", bus.rsp_valid, 0);
    check("t6_async_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    set_req(0, 1, 1, 4'd0);
    set_req(1, 9, 4, 4'd1);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t6_first_grant", bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b10;
    @(negedge clk);
    cycle();
    bus.req_valid = 2'b00;
    repeat (3) cycle();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: req 0 is the integer pipe, req 1 is the address/branch helper.
- Round-robin arbitration with valid/ready handshakes on both the request and the response sides.
- One issue register drives the ALU operand and opcode ports.
- The result returns to the owning requester, and the stage holds under backpressure.
- The ALU itself stays outside this block and connects through the alu_* ports.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 4, opcode width.
- MAX_OP, 9, highest legal opcode (SLT). Opcodes above this are flagged as errors.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_a  in  2*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B; same slicing as req_a.
- req_op  in  2*OPW  opcode; requester i uses slice [i*OPW +: OPW].
- rsp_valid  out  2  result valid for requester i.
- rsp_ready  in  2  requester i is taking the result.
- rsp_q  out  WIDTH  result, shared by both requesters; only meaningful when a rsp_valid bit is set.
- rsp_err  out  1  the returned op had an illegal opcode.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- alu_op  out  OPW  to ALU opcode.
- alu_q  in  WIDTH  from ALU result (combinational).
- busy  out  1  issue stage occupied.

Behaviour:
- Reset (async, rst=1):
  - occ=0, owner=0, last_grant=1 (so req 0 wins the first conflict).
  - alu_a, alu_b = 0; alu_op = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_err, busy, rsp_q.
  - Reset asserted mid-operation discards any in-flight op; no response is produced for it.
- Stage state:
  - occ: 1-bit occupancy.
  - owner: 1-bit requester id.
  - err: 1-bit, set when the op's opcode > MAX_OP.
  - Issue registers feed alu_a, alu_b, alu_op.
- free = !occ | (rsp_valid[owner] & rsp_ready[owner]). A drain and a new accept can happen in the same cycle, giving full throughput of one op per cycle.
- Arbitration (combinational, only when free):
  - Only one bit of req_valid set: grant that requester.
  - Both set: grant !last_grant.
  - req_ready[g] = free & req_valid[g]. The other bit is 0. When not free, both bits are 0.
  - Requesters must hold req_valid and their operands stable until accepted. Dropping valid before acceptance is allowed and loses the request.
- On accept (rising edge):
  - Issue registers load the granted operands and opcode.
  - owner=g, last_grant=g, occ=1.
  - err = (req_op_g > MAX_OP).
  - An illegal opcode still issues and still returns a response.
- Responses:
  - rsp_valid[owner] = occ. The other bit is 0.
  - rsp_q = err ? 0 : alu_q.
  - rsp_err = occ & err.
  - Latency: result visible the cycle after acceptance.
  - Backpressure: while rsp_ready[owner]=0, the stage holds and alu_a, alu_b, alu_op stay stable. Downstream may depend on this stability.
- On drain with no new accept: occ=0. The issue registers keep their last values; the ALU ports are not cleared.
- rsp_ready of the non-owner is ignored.
- busy = occ.
- Fairness: with both requesters continuously valid and responses always ready, grants alternate 0,1,0,1…, so neither requester waits more than one op.

Test Plan:
- Single requester: req 0 issues ADD A=5, B=7. Required: req_ready[0]=1 in the accept cycle (cycle 0); next cycle rsp_valid=2'b01, rsp_q=12, rsp_err=0.
- Contention after reset: both requesters valid.
  - Req 0 is SUB 10-3; req 1 is XOR 0xF0^0xFF.
  - Required grant order: 0 then 1.
  - Required responses: 7, then 0x0F, back-to-back with no idle cycle.
- Backpressure:
  - Req 1 issues SLL 1<<4 with rsp_ready[1]=0 for 3 cycles.
  - Required during the hold: rsp_q holds 16, alu_* stable, req_ready=0 even though req 0 is valid.
  - Required on the release cycle: req 0 is accepted in the same cycle.
- Illegal opcode: req 0 sends op=4'hC. Required: rsp_valid[0]=1, rsp_err=1, rsp_q=0. The next legal op returns with rsp_err=0.
- Streaming fairness: both requesters valid for 8 ops with responses always ready. Required grant sequence 0,1,0,1,0,1,0,1 and 8 results in 9 cycles.
- Reset mid-op:
  - Assert rst while occ=1 and rsp_ready=0.
  - Required immediately, without waiting for a clock edge: rsp_valid=0, busy=0.
  - After release: the first conflict grants requester 0.
